// File: rtl/viterbi_pkg.sv
// viterbi_pkg -- shared definitions for the Viterbi add-compare-select unit.
//   MAX_STATES : widest trellis supported (64 states, 6-bit state index)
//   acs_state_e: ACS control FSM states
//   PM_INIT_SHIFT / pm_init(): start metric for every state except state 0
//   n_states() : trellis size from the register_num code (64 >> code)
package viterbi_pkg;

  localparam int MAX_STATES    = 64;
  localparam int IDX_W         = 6;
  // Non-zero states start this many binary orders below full scale, so
  // state 0 dominates the first steps without saturating immediately.
  localparam int PM_INIT_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } acs_state_e;

  function automatic int pm_init(input int width_pm);
    return -(1 <<< (width_pm - PM_INIT_SHIFT));
  endfunction

  function automatic logic [IDX_W:0] n_states(input logic [1:0] register_num);
    return 7'd64 >> register_num;
  endfunction

endpackage

// File: rtl/acs_unit_if.sv
// acs_unit_if -- beat stream in, trellis-step decisions out.
//   frame_start_i   : one-cycle frame (re)start pulse
//   register_num_i  : trellis size code, N = 64 >> code
//   bm_i/bm_valid_i : signed low-path branch metric, one beat per state
//   ready_o         : unit is in RUN and consuming beats
//   decision_o      : survivor bit per state of the last completed step
//   decision_valid_o: one-cycle pulse per completed step
//   best_state_o    : index of the strongest state of the last step
// master = beat source / decision sink, slave = acs_unit.
interface acs_unit_if
  import viterbi_pkg::*;
#(
  parameter int WIDTH_BM = 9
);
  logic                         frame_start_i;
  logic [1:0]                   register_num_i;
  logic signed [WIDTH_BM-1:0]   bm_i;
  logic                         bm_valid_i;
  logic                         ready_o;
  logic [MAX_STATES-1:0]        decision_o;
  logic                         decision_valid_o;
  logic [IDX_W-1:0]             best_state_o;

  modport master (
    output frame_start_i, register_num_i, bm_i, bm_valid_i,
    input  ready_o, decision_o, decision_valid_o, best_state_o
  );

  modport slave (
    input  frame_start_i, register_num_i, bm_i, bm_valid_i,
    output ready_o, decision_o, decision_valid_o, best_state_o
  );
endinterface

// File: rtl/acs_cell.sv
// acs_cell -- combinational add-compare-select for one trellis state.
//   pm_low/pm_high : old metrics of the two predecessors
//   off            : normalisation offset subtracted from both
//   bm             : branch metric, added on the low path, subtracted on high
//   pm_sel         : saturated survivor metric
//   dec            : 1 when the high predecessor survives (ties go low)
module acs_cell #(
  parameter int WIDTH_BM = 9,
  parameter int WIDTH_PM = 12
) (
  input  logic signed [WIDTH_PM-1:0] pm_low,
  input  logic signed [WIDTH_PM-1:0] pm_high,
  input  logic signed [WIDTH_PM-1:0] off,
  input  logic signed [WIDTH_BM-1:0] bm,
  output logic signed [WIDTH_PM-1:0] pm_sel,
  output logic                       dec
);
  // Two guard bits: a full-scale metric minus a full-scale offset minus a
  // branch metric can exceed a single extra bit and must not wrap before
  // saturation.
  localparam int CW = WIDTH_PM + 2;
  localparam logic signed [CW-1:0] PM_MAX = {{(CW-WIDTH_PM+1){1'b0}}, {(WIDTH_PM-1){1'b1}}};
  localparam logic signed [CW-1:0] PM_MIN = {{(CW-WIDTH_PM+1){1'b1}}, {(WIDTH_PM-1){1'b0}}};

  logic signed [CW-1:0]       c_low, c_high;
  logic signed [WIDTH_PM-1:0] s_low, s_high;

  function automatic logic signed [WIDTH_PM-1:0] sat(input logic signed [CW-1:0] v);
    if (v > PM_MAX)      return PM_MAX[WIDTH_PM-1:0];
    else if (v < PM_MIN) return PM_MIN[WIDTH_PM-1:0];
    else                 return v[WIDTH_PM-1:0];
  endfunction

  assign c_low  = CW'(pm_low)  - CW'(off) + CW'(bm);
  assign c_high = CW'(pm_high) - CW'(off) - CW'(bm);
  assign s_low  = sat(c_low);
  assign s_high = sat(c_high);

  assign dec    = s_high > s_low;
  assign pm_sel = dec ? s_high : s_low;
endmodule

// File: rtl/acs_unit.sv
// acs_unit -- serial Viterbi add-compare-select, one state per beat.
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   rst_sync_i : synchronous clear, same effect as rst_i
//   bus        : acs_unit_if.slave (beats in, decisions out)
// Path metrics live in two banks: the step reads the old bank and writes the
// new one, and the roles swap on the last beat so the next step starts with
// no bubble. The running maximum of the written metrics becomes the next
// step's normalisation offset.
// Build option: define ACS_BEST_STATE_EN to track the best-state index and
// drive best_state_o; otherwise best_state_o is tied to 0.
module acs_unit
  import viterbi_pkg::*;
#(
  parameter int WIDTH_BM = 9,
  parameter int WIDTH_PM = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rst_sync_i,
  acs_unit_if.slave   bus
);
  localparam logic signed [WIDTH_PM-1:0] PM_INIT  = WIDTH_PM'(pm_init(WIDTH_PM));
  localparam logic signed [WIDTH_PM-1:0] PM_FLOOR = {1'b1, {(WIDTH_PM-1){1'b0}}};

  acs_state_e                   state_q, state_d;
  logic                         ready;
  logic                         bank;          // bank holding the old metrics
  logic [IDX_W-1:0]             x;
  logic [1:0]                   reg_num_q;
  logic signed [WIDTH_PM-1:0]   off, max_val, max_val_nxt;
  logic signed [WIDTH_PM-1:0]   pm [2][MAX_STATES];
  logic [MAX_STATES-1:0]        dec_acc, dec_full, decision_q;
  logic                         dv_q;

  logic [IDX_W:0]               n;
  logic [IDX_W-1:0]             p_low, p_high;
  logic                         last, beat, upd, dec;
  logic signed [WIDTH_PM-1:0]   pm_low, pm_high, pm_sel;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    if (rst_sync_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.frame_start_i) state_d = ST_INIT;
        ST_INIT: state_d = ST_RUN;
        ST_RUN: begin
          ready = 1'b1;
          if (bus.frame_start_i) state_d = ST_INIT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.ready_o = ready;

  // ---------------- datapath ----------------
  assign n      = n_states(reg_num_q);
  assign last   = (x == IDX_W'(n - 7'd1));
  assign p_low  = x >> 1;
  assign p_high = p_low + IDX_W'(n >> 1);
  assign pm_low  = pm[bank][p_low];
  assign pm_high = pm[bank][p_high];

  // A frame restart takes priority over the beat presented with it.
  assign beat = (state_q == ST_RUN) && bus.bm_valid_i && !bus.frame_start_i;

  acs_cell #(.WIDTH_BM(WIDTH_BM), .WIDTH_PM(WIDTH_PM)) u_cell (
    .pm_low  (pm_low),
    .pm_high (pm_high),
    .off     (off),
    .bm      (bus.bm_i),
    .pm_sel  (pm_sel),
    .dec     (dec)
  );

  // Strict compare: with x ascending, a tie keeps the lower index.
  assign upd         = pm_sel > max_val;
  assign max_val_nxt = upd ? pm_sel : max_val;

  always_comb begin
    dec_full    = dec_acc;
    dec_full[x] = dec;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank       <= 1'b0;
      x          <= '0;
      reg_num_q  <= '0;
      off        <= '0;
      max_val    <= '0;
      dec_acc    <= '0;
      decision_q <= '0;
      dv_q       <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < MAX_STATES; s++) pm[b][s] <= '0;
    end else if (rst_sync_i) begin
      bank       <= 1'b0;
      x          <= '0;
      reg_num_q  <= '0;
      off        <= '0;
      max_val    <= '0;
      dec_acc    <= '0;
      decision_q <= '0;
      dv_q       <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < MAX_STATES; s++) pm[b][s] <= '0;
    end else begin
      dv_q <= 1'b0;
      if (state_q == ST_INIT) begin
        reg_num_q <= bus.register_num_i;
        x         <= '0;
        off       <= '0;
        max_val   <= PM_FLOOR;
        dec_acc   <= '0;
        for (int s = 0; s < MAX_STATES; s++)
          pm[bank][s] <= (s == 0) ? '0 : PM_INIT;
      end else if (beat) begin
        pm[!bank][x] <= pm_sel;
        if (last) begin
          bank       <= !bank;
          x          <= '0;
          off        <= max_val_nxt;
          max_val    <= PM_FLOOR;
          dec_acc    <= '0;
          decision_q <= dec_full;
          dv_q       <= 1'b1;
        end else begin
          x       <= x + 1'b1;
          max_val <= max_val_nxt;
          dec_acc <= dec_full;
        end
      end
    end
  end

  assign bus.decision_o       = decision_q;
  assign bus.decision_valid_o = dv_q;

`ifdef ACS_BEST_STATE_EN
  logic [IDX_W-1:0] max_idx, max_idx_nxt, best_q;

  assign max_idx_nxt = upd ? x : max_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_idx <= '0;
      best_q  <= '0;
    end else if (rst_sync_i) begin
      max_idx <= '0;
      best_q  <= '0;
    end else if (state_q == ST_INIT) begin
      max_idx <= '0;
    end else if (beat) begin
      if (last) begin
        best_q  <= max_idx_nxt;
        max_idx <= '0;
      end else begin
        max_idx <= max_idx_nxt;
      end
    end
  end

  assign bus.best_state_o = best_q;
`else
  assign bus.best_state_o = '0;
`endif

endmodule
